pc_fetch_unit: RTL and testbench
================================

Name: pc_fetch_unit

Overview:
- Owns the program counter and fetches instructions from instruction memory over a valid/ready request/response interface.
- Presents fetched instructions to decode with a valid/ready handshake.
- Consumes the resolved next-PC redirect that the branch/jump select path produces: branch-taken target or jump target. On a redirect it steers fetch to the target and squashes wrong-path work.
- Sits between the branch/jump select logic and the IF/ID boundary.

Parameters:
- DATA_W, 32, width of PC, addresses, targets and instruction words.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- br_taken  input  1  branch resolved taken this cycle (older instruction, from EX).
- br_target  input  DATA_W  branch target (PC plus sign-extended immediate).
- jump_en  input  1  jump redirect this cycle (from ID).
- jump_target  input  DATA_W  jump target address.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  DATA_W  fetch address.
- imem_rsp_valid  input  1  response data valid; arrives at least 1 cycle after acceptance.
- imem_rsp_data  input  DATA_W  instruction word.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts instruction.
- if_instr  output  DATA_W  fetched instruction.
- if_pc  output  DATA_W  address of if_instr.

Behaviour:

Reset (rst=1 at clock edge):
- pc=RESET_PC, state=REQ, drop=0.
- if_valid=0, if_instr=0, if_pc=0.
- rst overrides every other input, including mid-transaction. A memory response arriving in the cycle after reset is ignored because state is REQ.
- imem_req_valid is 0 while rst is high.

Redirect decode:
- redirect = br_taken | jump_en.
- Target = br_target if br_taken, else jump_target. Branch has priority over jump when both are high.
- Target bits [1:0] are forced to 0. pc[1:0] is always 00.

States:
- REQ (request phase):
  - imem_req_valid = (state==REQ) & outbuf_free & ~redirect & ~rst, where outbuf_free = ~if_valid | if_ready.
  - imem_req_addr = pc, held stable while valid and not ready.
  - On accept (valid & ready): req_pc<=pc, pc<=pc+PC_STEP (mod 2^DATA_W, wraps 32'hFFFF_FFFC -> 0), go to WAIT.
- WAIT (one request outstanding; no new request issued):
  - On imem_rsp_valid with drop=1 or redirect=1: discard the response, clear drop, go to REQ.
  - On imem_rsp_valid otherwise: if_instr<=imem_rsp_data, if_pc<=req_pc, if_valid<=1, go to REQ.
- Output register:
  - if_valid clears on if_valid & if_ready unless reloaded in the same cycle.
  - Load and consume in the same cycle is allowed: new data replaces old and if_valid stays 1.
  - if_instr and if_pc hold while if_valid & ~if_ready.

Redirect in any state (no rst):
- pc<=target and if_valid<=0.
- A handshake in the redirect cycle is not a transfer; decode must discard it.
- In WAIT without a response this cycle: drop<=1, so the next response is discarded.
- In WAIT with a response this cycle: the response is discarded directly, drop stays 0.
- In REQ: no request is issued that cycle. The next request goes to the target address one cycle later.

Other rules:
- At most one outstanding request.
- Minimum spacing is 2 cycles per instruction with zero-wait memory.
- A response when state!=WAIT is ignored.

Test Plan:
1. Reset then sequential fetch: rst 1 cycle; memory ready=1, returns 1 cycle later; if_ready=1. Required: imem_req_addr 0x0, 0x4, 0x8 on successive requests; if_pc 0x0/0x4/0x8 with matching instructions.
2. Decode stall: if_ready=0 for 5 cycles after if_valid with if_pc=0x4. Required: if_instr/if_pc stable, no new request issued. After if_ready=1, the next request addr is 0x8.
3. Branch while waiting: request to 0x10 accepted; br_taken=1, br_target=0x40 while in WAIT; response arrives 3 cycles later. Required: response dropped, if_valid stays 0, next request addr is 0x40.
4. Simultaneous redirects: br_taken=1 with br_target=0x100, jump_en=1 with jump_target=0x200, same cycle. Required: next request 0x100. Also br_target=0x103 must produce 0x100.
5. Wrap-around: RESET_PC=32'hFFFF_FFFC. Required: first request at 0xFFFF_FFFC, then 0x0.
6. Reset mid-transaction: rst asserted in WAIT with a response arriving the next cycle. Required: response ignored, if_valid=0, first post-reset request at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the program counter, fetches instruction words over a
// valid/ready memory interface with at most one request outstanding, and
// presents them to decode through a one-entry output register.
// A branch/jump redirect steers fetch to the target and squashes wrong-path
// work, including a response still in flight.
module pc_fetch_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              br_taken,
  input  logic [DATA_W-1:0] br_target,
  input  logic              jump_en,
  input  logic [DATA_W-1:0] jump_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [DATA_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [DATA_W-1:0] if_pc
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  typedef enum logic {
    ST_REQ,
    ST_WAIT
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] req_pc;
  logic              drop;

  logic              redirect;
  logic [DATA_W-1:0] target;
  logic              outbuf_free;
  logic              req_fire;
  logic              rsp_in_wait;
  logic              rsp_keep;

  // Redirect decode: branch (older instruction) wins over jump; targets are
  // word aligned so pc[1:0] stays 00.
  always_comb begin
    redirect = br_taken | jump_en;
    target   = br_taken ? br_target : jump_target;
    target   = {target[DATA_W-1:2], 2'b00};
  end

  // Next-state and request-side outputs of the fetch FSM.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt      = state;
    imem_req_valid = 1'b0;
    outbuf_free    = ~if_valid | if_ready;
    rsp_in_wait    = (state == ST_WAIT) & imem_rsp_valid;
    rsp_keep       = rsp_in_wait & ~drop & ~redirect;
    imem_req_addr  = pc;

    imem_req_valid = (state == ST_REQ) & outbuf_free & ~redirect & ~rst;
    req_fire       = imem_req_valid & imem_req_ready;

    case (state)
      ST_REQ:  if (req_fire)       state_nxt = ST_WAIT;
      ST_WAIT: if (imem_rsp_valid) state_nxt = ST_REQ;
      default:                     state_nxt = ST_REQ;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= ST_REQ;
    else     state <= state_nxt;
  end

  // PC, squash flag and decode output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the instruction/pc output registers are reset too, so decode
      // sees defined zeros rather than X before the first fetch lands.
      pc       <= RESET_PC;
      req_pc   <= RESET_PC;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (redirect) begin
      pc       <= target;
      if_valid <= 1'b0;
      // A response still in flight belongs to the wrong path: if it is not
      // here this cycle, remember to throw the next one away.
      if (state == ST_WAIT) drop <= ~imem_rsp_valid;
    end else begin
      if (req_fire) begin
        req_pc <= pc;
        pc     <= pc + STEP;
      end
      if (rsp_keep) begin
        if_instr <= imem_rsp_data;
        if_pc    <= req_pc;
        if_valid <= 1'b1;
      end else if (if_valid & if_ready) begin
        if_valid <= 1'b0;
      end
      if (rsp_in_wait) drop <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: drives two fetch units (RESET_PC = 0 and 0xFFFF_FFFC)
// with identical directed and random stimulus and compares every output,
// every cycle, against a behavioural model of fetch/redirect/decode rules.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_A = 32'h0000_0000;
  localparam logic [31:0] RST_B = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_target = '0;
  logic        imem_req_ready = 1'b0;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_ready = 1'b0;

  logic        req_valid_a, req_valid_b;
  logic [31:0] req_addr_a, req_addr_b;
  logic        if_valid_a, if_valid_b;
  logic [31:0] if_instr_a, if_instr_b;
  logic [31:0] if_pc_a, if_pc_b;

  always #5 clk = ~clk;

  pc_fetch_unit #(.DATA_W(32), .RESET_PC(RST_A), .PC_STEP(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .br_taken(br_taken), .br_target(br_target),
    .jump_en(jump_en), .jump_target(jump_target),
    .imem_req_valid(req_valid_a), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr_a),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid_a), .if_ready(if_ready),
    .if_instr(if_instr_a), .if_pc(if_pc_a)
  );

  pc_fetch_unit #(.DATA_W(32), .RESET_PC(RST_B), .PC_STEP(4)) u_dut_b (
    .clk(clk), .rst(rst),
    .br_taken(br_taken), .br_target(br_target),
    .jump_en(jump_en), .jump_target(jump_target),
    .imem_req_valid(req_valid_b), .imem_req_ready(imem_req_ready),
    .imem_req_addr(req_addr_b),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid_b), .if_ready(if_ready),
    .if_instr(if_instr_b), .if_pc(if_pc_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
  endtask

  // Behavioural model. Control behaviour is address independent, so one
  // set of flags serves both units; only the addresses differ per unit.
  bit          m_pending;   // a request has been accepted, response not yet seen
  bit          m_squash;    // the pending response belongs to a squashed path
  bit          m_have;      // decode has an instruction waiting
  logic [31:0] m_instr;
  logic [31:0] m_pc   [2];
  logic [31:0] m_reqpc[2];
  logic [31:0] m_ifpc [2];

  // One clock cycle: drive inputs after the falling edge, check outputs, then
  // advance the model to what the next rising edge must produce.
  task automatic cycle(input bit r, input bit b, input logic [31:0] bt,
                       input bit j, input logic [31:0] jt,
                       input bit rdy, input bit rspv, input bit ifr, input bit do_chk);
    bit          redir;
    bit          exp_rv;
    logic [31:0] tgt;
    @(negedge clk);
    rst            = r;
    br_taken       = b;
    br_target      = bt;
    jump_en        = j;
    jump_target    = jt;
    imem_req_ready = rdy;
    imem_rsp_valid = rspv;
    imem_rsp_data  = $urandom;
    if_ready       = ifr;
    #1;
    redir  = b | j;
    tgt    = (b ? bt : jt) & 32'hFFFF_FFFC;
    exp_rv = !r && !m_pending && (!m_have || ifr) && !redir;
    if (do_chk) begin
      check("req_valid_a", {31'b0, req_valid_a}, {31'b0, exp_rv});
      check("req_valid_b", {31'b0, req_valid_b}, {31'b0, exp_rv});
      check("req_addr_a", req_addr_a, m_pc[0]);
      check("req_addr_b", req_addr_b, m_pc[1]);
      check("if_valid_a", {31'b0, if_valid_a}, {31'b0, m_have});
      check("if_valid_b", {31'b0, if_valid_b}, {31'b0, m_have});
      check("if_instr_a", if_instr_a, m_instr);
      check("if_instr_b", if_instr_b, m_instr);
      check("if_pc_a", if_pc_a, m_ifpc[0]);
      check("if_pc_b", if_pc_b, m_ifpc[1]);
    end
    if (r) begin
      m_pending = 0; m_squash = 0; m_have = 0; m_instr = '0;
      m_pc[0] = RST_A; m_pc[1] = RST_B;
      m_ifpc[0] = '0;  m_ifpc[1] = '0;
    end else if (redir) begin
      m_pc[0] = tgt; m_pc[1] = tgt;
      m_have  = 0;
      if (m_pending) begin
        if (rspv) begin m_pending = 0; m_squash = 0; end
        else      m_squash = 1;
      end
    end else begin
      if (m_have && ifr) m_have = 0;
      if (exp_rv && rdy) begin
        for (int i = 0; i < 2; i++) begin
          m_reqpc[i] = m_pc[i];
          m_pc[i]    = m_pc[i] + 32'd4;
        end
        m_pending = 1;
      end else if (m_pending && rspv) begin
        m_pending = 0;
        if (m_squash) m_squash = 0;
        else begin
          m_have  = 1;
          m_instr = imem_rsp_data;
          m_ifpc  = m_reqpc;
        end
      end
    end
  endtask

  // Quiet cycles: memory always ready, response one cycle after acceptance.
  task automatic run_quiet(input int n, input bit ifr);
    for (int k = 0; k < n; k++) cycle(0, 0, '0, 0, '0, 1, m_pending, ifr, 1);
  endtask

  initial begin
    bit stall_mode;
    // Reset: the first edge defines the registers, the second cycle checks them.
    cycle(1, 0, '0, 0, '0, 0, 0, 0, 0);
    cycle(1, 0, '0, 0, '0, 1, 1, 1, 1);

    // Sequential fetch (unit b wraps 0xFFFF_FFFC -> 0).
    run_quiet(8, 1);
    // Decode stall, then release.
    run_quiet(6, 0);
    run_quiet(6, 1);

    // Branch while a request is outstanding; the late response must be dropped.
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(0, 1, 32'h40, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 0, '0, 1, m_pending, 1, 1);
    run_quiet(4, 1);

    // Simultaneous branch and jump, aligned and unaligned branch target.
    cycle(0, 1, 32'h100, 1, 32'h200, 1, m_pending, 1, 1);
    run_quiet(4, 1);
    cycle(0, 1, 32'h103, 1, 32'h200, 1, m_pending, 1, 1);
    run_quiet(4, 1);
    cycle(0, 0, '0, 1, 32'h301, 1, m_pending, 1, 1);
    run_quiet(4, 1);

    // Reset mid-transaction with a response arriving right after reset.
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(1, 0, '0, 0, '0, 1, 0, 1, 1);
    cycle(0, 0, '0, 0, '0, 0, 1, 1, 1);
    run_quiet(6, 1);

    // Random traffic.
    stall_mode = 0;
    for (int n = 0; n < 3000 && (n_checks - n_pass) < 100; n++) begin
      bit          r, b, j, rdy, rspv, ifr;
      logic [31:0] bt, jt;
      if (n % 200 == 0) stall_mode = ~stall_mode;
      r    = ($urandom_range(63) == 0);
      b    = ($urandom_range(9) == 0);
      j    = ($urandom_range(9) == 0);
      bt   = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      jt   = ($urandom_range(3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      rdy  = ($urandom_range(9) < 7);
      rspv = m_pending ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
      ifr  = ($urandom_range(9) < (stall_mode ? 2 : 8));
      cycle(r, b, bt, j, jt, rdy, rspv, ifr, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
